// File: rtl/axis_red_pitaya_adc_dec.sv
// Multi-channel ADC front end: converts inverted ADC codes to two's complement, sums
// cfg_rate consecutive samples per channel and presents the sums on a single-entry AXIS register.
module axis_red_pitaya_adc_dec #(
   parameter int ADC_DATA_WIDTH = 14,
   parameter int CHANNELS       = 2,
   parameter int CNTR_WIDTH     = 16
) (
   input  logic                    aclk,
   input  logic                    areset,
   output logic                    adc_csn,
   input  logic [16*CHANNELS-1:0]  adc_dat,
   input  logic [CNTR_WIDTH-1:0]   cfg_rate,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tvalid,
   output logic [32*CHANNELS-1:0]  m_axis_tdata,
   output logic [31:0]             sts_drop
);
   localparam int ACC_W = ADC_DATA_WIDTH + CNTR_WIDTH;

   // MSB keeps its weight, the remaining bits arrive inverted from the converter.
   function automatic logic signed [ACC_W-1:0] adc_to_signed(input logic [ADC_DATA_WIDTH-1:0] raw);
      logic signed [ADC_DATA_WIDTH-1:0] x;
      x = {raw[ADC_DATA_WIDTH-1], ~raw[ADC_DATA_WIDTH-2:0]};
      return ACC_W'(x);
   endfunction

   function automatic logic [31:0] sext_lane(input logic signed [ACC_W-1:0] v);
      return 32'(v);
   endfunction

   assign adc_csn = 1'b1;

   logic unused_adc_bits;
   assign unused_adc_bits = ^adc_dat;

   // Stage p0: capture the significant bits of each raw ADC word.
   logic [ADC_DATA_WIDTH-1:0] raw_p0 [CHANNELS];
   logic                      vld_p0;

   always_ff @(posedge aclk) begin
      for (int k = 0; k < CHANNELS; k++) begin
         raw_p0[k] <= adc_dat[16*k+15 -: ADC_DATA_WIDTH];
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) vld_p0 <= 1'b0;
      else        vld_p0 <= 1'b1;
   end

   // Stage p1: per-channel accumulation over a window of rate_eff samples.
   logic signed [ACC_W-1:0] x_p0   [CHANNELS];
   logic signed [ACC_W-1:0] acc_p1 [CHANNELS];
   logic signed [ACC_W-1:0] sum_p1 [CHANNELS];
   logic [CNTR_WIDTH-1:0]   cnt_p1;
   logic [CNTR_WIDTH-1:0]   rate_p1;
   logic [CNTR_WIDTH-1:0]   cfg_eff;
   logic [CNTR_WIDTH-1:0]   rate_eff;
   logic                    win_end;

   always_comb begin
      for (int k = 0; k < CHANNELS; k++) begin
         x_p0[k]   = adc_to_signed(raw_p0[k]);
         sum_p1[k] = acc_p1[k] + x_p0[k];
      end
   end

   // At counter 0 a new window begins, so the live cfg_rate applies; otherwise the latched one.
   assign cfg_eff  = (cfg_rate == '0) ? CNTR_WIDTH'(1) : cfg_rate;
   assign rate_eff = (cnt_p1 == '0) ? cfg_eff : rate_p1;
   assign win_end  = vld_p0 && (cnt_p1 == rate_eff - CNTR_WIDTH'(1));

   always_ff @(posedge aclk) begin
      if (areset) begin
         cnt_p1  <= '0;
         rate_p1 <= CNTR_WIDTH'(1);
         for (int k = 0; k < CHANNELS; k++) acc_p1[k] <= '0;
      end else if (vld_p0) begin
         if (cnt_p1 == '0) rate_p1 <= cfg_eff;
         if (win_end) begin
            cnt_p1 <= '0;
            for (int k = 0; k < CHANNELS; k++) acc_p1[k] <= '0;
         end else begin
            cnt_p1 <= cnt_p1 + CNTR_WIDTH'(1);
            for (int k = 0; k < CHANNELS; k++) acc_p1[k] <= sum_p1[k];
         end
      end
   end

   // Stage p2: single-entry output register; a result arriving while stalled is dropped.
   logic [32*CHANNELS-1:0] tdata_p1;

   always_comb begin
      tdata_p1 = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         tdata_p1[32*k +: 32] = sext_lane(sum_p1[k]);
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         sts_drop      <= '0;
      end else if (win_end) begin
         if (!m_axis_tvalid || m_axis_tready) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= tdata_p1;
         end else if (sts_drop != 32'hFFFF_FFFF) begin
            sts_drop <= sts_drop + 32'd1;
         end
      end else if (m_axis_tvalid && m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axis_red_pitaya_adc_dec.sv
// Bench for axis_red_pitaya_adc_dec: default 2-channel instance plus a 4-channel, 12-bit instance.
module tb_axis_red_pitaya_adc_dec;
   logic         clk = 1'b0;
   logic         areset, tready, tvalid, adc_csn;
   logic [31:0]  adc_dat;
   logic [15:0]  cfg_rate;
   logic [63:0]  tdata;
   logic [31:0]  sts_drop;

   logic         areset4, tready4, tvalid4, adc_csn4;
   logic [63:0]  adc_dat4;
   logic [15:0]  cfg_rate4;
   logic [127:0] tdata4;
   logic [31:0]  sts_drop4;

   int checks = 0;
   int errors = 0;
   logic [63:0]  q  [$];
   logic [127:0] q4 [$];
   logic [63:0]  exp_beat;
   logic [127:0] exp_beat4;

   always #5 clk = ~clk;

   axis_red_pitaya_adc_dec dut (
      .aclk(clk), .areset(areset), .adc_csn(adc_csn), .adc_dat(adc_dat), .cfg_rate(cfg_rate),
      .m_axis_tready(tready), .m_axis_tvalid(tvalid), .m_axis_tdata(tdata), .sts_drop(sts_drop)
   );

   axis_red_pitaya_adc_dec #(.ADC_DATA_WIDTH(12), .CHANNELS(4), .CNTR_WIDTH(16)) dut4 (
      .aclk(clk), .areset(areset4), .adc_csn(adc_csn4), .adc_dat(adc_dat4), .cfg_rate(cfg_rate4),
      .m_axis_tready(tready4), .m_axis_tvalid(tvalid4), .m_axis_tdata(tdata4), .sts_drop(sts_drop4)
   );

   // Scoreboard: every accepted beat is matched against the oldest expected entry.
   always @(negedge clk) begin
      if (tvalid && tready && q.size() > 0) begin
         exp_beat = q.pop_front();
         checks++;
         if (tdata !== exp_beat) begin
            errors++;
            $display("FAIL beat got %h want %h", tdata, exp_beat);
         end
      end
      if (tvalid4 && tready4 && q4.size() > 0) begin
         exp_beat4 = q4.pop_front();
         checks++;
         if (tdata4 !== exp_beat4) begin
            errors++;
            $display("FAIL beat4 got %h want %h", tdata4, exp_beat4);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] b2(input int l1, input int l0);
      return {l1, l0};
   endfunction

   function automatic logic [127:0] b4(input int l3, input int l2, input int l1, input int l0);
      return {l3, l2, l1, l0};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(output bit ok);
      int n = 0;
      while ((q.size() > 0 || q4.size() > 0) && n < 60) begin
         tick(1);
         n++;
      end
      ok = (q.size() == 0 && q4.size() == 0);
   endtask

   task automatic test_reset;
      tick(3);
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
      checks++; if (tdata !== 64'd0) begin errors++; $display("FAIL reset_tdata got %h want 0", tdata); end
      checks++; if (sts_drop !== 32'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", sts_drop); end
      checks++; if (adc_csn !== 1'b1) begin errors++; $display("FAIL reset_csn got %b want 1", adc_csn); end
      checks++; if (tvalid4 !== 1'b0) begin errors++; $display("FAIL reset_tvalid4 got %b want 0", tvalid4); end
   endtask

   task automatic test_rate1;
      logic [15:0] v [4] = '{16'h0000, 16'hFFFC, 16'h8000, 16'h7FFC};
      int          e [4] = '{8191, -8192, -1, 0};
      bit ok;
      areset = 1'b1; cfg_rate = 16'd1; tready = 1'b1;
      tick(1);
      areset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         adc_dat = {16'h0000, v[i]};
         q.push_back(b2(8191, e[i]));
         tick(1);
         checks++;
         if (tvalid !== (i >= 1)) begin errors++; $display("FAIL rate1_valid i=%0d got %b want %b", i, tvalid, i >= 1); end
      end
      tick(1);
      checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL rate1_stream got %b want 1", tvalid); end
      drain(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rate1_drain left %0d want 0", q.size()); end
   endtask

   task automatic test_rate4;
      bit ok;
      areset = 1'b1; tready = 1'b1;
      tick(1);
      cfg_rate = 16'd4;
      adc_dat = {16'hFFFC, 16'h0000};
      repeat (2) q.push_back(b2(-32768, 32764));
      areset = 1'b0;
      for (int t = 1; t <= 12; t++) begin
         tick(1);
         checks++;
         if (tvalid !== (t == 5 || t == 9)) begin errors++; $display("FAIL rate4_valid t=%0d got %b", t, tvalid); end
      end
      areset = 1'b1;
      tick(1);
      cfg_rate = 16'd0;
      repeat (4) q.push_back(b2(-8192, 8191));
      areset = 1'b0;
      for (int t = 1; t <= 5; t++) begin
         tick(1);
         checks++;
         if (tvalid !== (t >= 2)) begin errors++; $display("FAIL rate0_valid t=%0d got %b", t, tvalid); end
      end
      drain(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rate4_drain left %0d want 0", q.size()); end
   endtask

   task automatic test_back_to_back;
      bit ok;
      areset = 1'b1; tready = 1'b1;
      tick(1);
      cfg_rate = 16'd1;
      adc_dat = {16'h0000, 16'h0000};
      q.push_back(b2(8191, 8191));
      areset = 1'b0;
      for (int t = 1; t <= 16; t++) begin
         tick(1);
         if (t >= 2 && t <= 12) begin
            checks++;
            if (tvalid !== 1'b1 || tdata !== b2(8191, 8191)) begin
               errors++; $display("FAIL stall_hold t=%0d got %b/%h want 1/%h", t, tvalid, tdata, b2(8191, 8191));
            end
         end
         if (t == 2) tready = 1'b0;
         if (t == 12) begin
            checks++;
            if (sts_drop !== 32'd10) begin errors++; $display("FAIL stall_drop got %0d want 10", sts_drop); end
            tready = 1'b1;
         end
         if (t == 16) begin
            checks++;
            if (sts_drop !== 32'd10 || tvalid !== 1'b1) begin
               errors++; $display("FAIL stall_resume got %0d/%b want 10/1", sts_drop, tvalid);
            end
         end
         adc_dat = {16'h0000, 16'(t << 2)};
         if (t == 11 || t == 12) q.push_back(b2(8191, 8191 - t));
      end
      drain(ok);
      checks++; if (!ok) begin errors++; $display("FAIL stall_drain left %0d want 0", q.size()); end
   endtask

   task automatic test_rate_change;
      bit ok;
      areset = 1'b1; tready = 1'b1;
      tick(1);
      cfg_rate = 16'd4;
      adc_dat = {16'h8000, 16'h0000};
      q.push_back(b2(-4, 32764));
      repeat (3) q.push_back(b2(-2, 16382));
      areset = 1'b0;
      for (int t = 1; t <= 11; t++) begin
         tick(1);
         checks++;
         if (tvalid !== (t == 5 || t == 7 || t == 9 || t == 11)) begin
            errors++; $display("FAIL ratechg_valid t=%0d got %b", t, tvalid);
         end
         if (t == 2) cfg_rate = 16'd2;
      end
      drain(ok);
      checks++; if (!ok) begin errors++; $display("FAIL ratechg_drain left %0d want 0", q.size()); end
   endtask

   task automatic test_reset_mid;
      bit ok;
      areset = 1'b1; tready = 1'b0;
      tick(1);
      cfg_rate = 16'd4;
      adc_dat = {16'h0000, 16'h0000};
      areset = 1'b0;
      for (int t = 1; t <= 7; t++) begin
         tick(1);
         adc_dat = {16'h0000, 16'(t << 2)};
      end
      checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL midrst_pre got %b want 1", tvalid); end
      areset = 1'b1;
      tick(1);
      areset = 1'b0;
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid got %b want 0", tvalid); end
      checks++; if (sts_drop !== 32'd0) begin errors++; $display("FAIL midrst_drop got %0d want 0", sts_drop); end
      tready = 1'b1;
      adc_dat = {16'h0000, 16'(8 << 2)};
      q.push_back(b2(32764, 32726));
      for (int t = 9; t <= 13; t++) begin
         tick(1);
         adc_dat = {16'h0000, 16'(t << 2)};
         checks++;
         if (tvalid !== (t == 13)) begin errors++; $display("FAIL midrst_valid t=%0d got %b", t, tvalid); end
      end
      drain(ok);
      checks++; if (!ok) begin errors++; $display("FAIL midrst_drain left %0d want 0", q.size()); end
   endtask

   task automatic test_four_channel;
      bit ok;
      cfg_rate4 = 16'd16;
      tready4 = 1'b1;
      adc_dat4 = {16'h1230, 16'h8000, 16'hFFF0, 16'h0000};
      repeat (2) q4.push_back(b4(28096, -16, -32768, 32752));
      areset4 = 1'b0;
      for (int t = 1; t <= 34; t++) begin
         tick(1);
         checks++;
         if (tvalid4 !== (t == 17 || t == 33)) begin errors++; $display("FAIL ch4_valid t=%0d got %b", t, tvalid4); end
      end
      checks++;
      if (sts_drop4 !== 32'd0 || adc_csn4 !== 1'b1) begin
         errors++; $display("FAIL ch4_status got %0d/%b want 0/1", sts_drop4, adc_csn4);
      end
      drain(ok);
      checks++; if (!ok) begin errors++; $display("FAIL ch4_drain left %0d want 0", q4.size()); end
   endtask

   initial begin
      areset = 1'b1; tready = 1'b1; cfg_rate = 16'd1; adc_dat = '0;
      areset4 = 1'b1; tready4 = 1'b1; cfg_rate4 = 16'd16; adc_dat4 = '0;
      test_reset();
      test_rate1();
      test_rate4();
      test_back_to_back();
      test_rate_change();
      test_reset_mid();
      test_four_channel();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
